// File: rtl/hdmi_period_sched_if.sv
// Packetizer handshake plus the per-character period description fed to the TMDS encoders.
// Latency: none, signal bundle only.
// Backpressure: o_pkt_ready is a one-cycle offer; a transfer happens only when i_pkt_valid is high with it.
interface hdmi_period_sched_if;
    logic        i_pkt_valid;
    logic        o_pkt_ready;
    logic [4:0]  o_pkt_idx;
    logic [1:0]  o_dtype;
    logic        o_gtype;
    logic [1:0]  o_ctl0;
    logic [1:0]  o_ctl1;
    logic [1:0]  o_ctl2;
    logic [11:0] o_hpos;
    logic [11:0] o_vpos;

    // Packetizer / encoder side
    modport master (
        output i_pkt_valid,
        input  o_pkt_ready, o_pkt_idx, o_dtype, o_gtype,
        input  o_ctl0, o_ctl1, o_ctl2, o_hpos, o_vpos
    );

    // Scheduler side
    modport slave (
        input  i_pkt_valid,
        output o_pkt_ready, o_pkt_idx, o_dtype, o_gtype,
        output o_ctl0, o_ctl1, o_ctl2, o_hpos, o_vpos
    );
endinterface

// File: rtl/hdmi_period_sched.sv
// HDMI raster counter and per-character period scheduler (video, preamble, guard, data island, control).
// Latency: all outputs registered together, one clock after the raster counter; (0,0) is presented first clock after reset.
// Backpressure: none on the raster; an island runs only if i_pkt_valid is high during the o_pkt_ready cycle.
// Data-island scheduling is compiled in only when HDMI_ISLAND_EN is defined.
module hdmi_period_sched #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNCW  = 40,
    parameter int H_TOTAL  = 1650,
    parameter int V_ACTIVE = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNCW  = 5,
    parameter int V_TOTAL  = 750
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    hdmi_period_sched_if.slave bus
);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] HS_BEG     = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNCW);
    localparam logic [11:0] VS_BEG     = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNCW);
    localparam logic [11:0] VPRE_BEG   = 12'(H_TOTAL - 10);
    localparam logic [11:0] VGRD_BEG   = 12'(H_TOTAL - 2);

    // h_q/v_q address the character whose outputs are being computed this cycle
    logic [11:0] h_q, h_d, v_q, v_d;
    logic        hsync, vsync, next_line_act;

    logic [1:0]  dtype_q, dtype_d;
    logic        gtype_q, gtype_d;
    logic [1:0]  ctl1_q, ctl1_d;
    logic [1:0]  ctl2_q, ctl2_d;
    logic [1:0]  ctl0_q;
    logic [4:0]  idx_q, idx_d;
    logic [11:0] hpos_q, vpos_q;

    assign hsync         = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync         = (v_q >= VS_BEG) && (v_q < VS_END);
    assign next_line_act = (v_q < V_ACT_LAST) || (v_q == V_LAST);

    // Raster advance: h wraps each line, v steps on h wrap and wraps each frame
    always_comb begin
        h_d = h_q + 12'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
        end
    end

    // Raster counter register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

`ifdef HDMI_ISLAND_EN
    typedef enum logic [2:0] {IDLE, PRE, LGUARD, DATA, TGUARD} state_t;

    // state_q/sub_q describe the character currently presented on the outputs
    state_t     state_q, state_d;
    logic [4:0] sub_q, sub_d;
    logic       ready_q, ready_d;
    logic       accept;

    assign accept          = ready_q & bus.i_pkt_valid;
    assign ready_d         = (h_q == 12'(H_ACTIVE + 3));
    assign bus.o_pkt_ready = ready_q;

    // Island FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            sub_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            ready_q <= ready_d;
        end
    end

    // Island FSM next state: 8 preamble, 2 guard, 32 data, 2 guard characters
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q + 5'd1;
        case (state_q)
            IDLE: begin
                sub_d = '0;
                if (accept) state_d = PRE;
            end
            PRE:    if (sub_q == 5'd7)  begin state_d = LGUARD; sub_d = '0; end
            LGUARD: if (sub_q == 5'd1)  begin state_d = DATA;   sub_d = '0; end
            DATA:   if (sub_q == 5'd31) begin state_d = TGUARD; sub_d = '0; end
            TGUARD: if (sub_q == 5'd1)  begin state_d = IDLE;   sub_d = '0; end
            default: begin
                state_d = IDLE;
                sub_d   = '0;
            end
        endcase
    end
`else
    logic pkt_valid_unused;
    assign pkt_valid_unused = bus.i_pkt_valid;
    assign bus.o_pkt_ready  = 1'b0;
`endif

    // Period decode for the character at (h_q, v_q); islands sit in blanking before the video preamble
    always_comb begin
        dtype_d = 2'b01;
        gtype_d = 1'b0;
        ctl1_d  = 2'b00;
        ctl2_d  = 2'b00;
        idx_d   = '0;
        if ((h_q < H_ACT) && (v_q < V_ACT)) begin
            dtype_d = 2'b11;
        end else if (next_line_act && (h_q >= VGRD_BEG)) begin
            dtype_d = 2'b00;
        end else if (next_line_act && (h_q >= VPRE_BEG)) begin
            ctl1_d = 2'b01;
        end
`ifdef HDMI_ISLAND_EN
        case (state_d)
            PRE: begin
                ctl1_d = 2'b01;
                ctl2_d = 2'b01;
            end
            LGUARD, TGUARD: begin
                dtype_d = 2'b00;
                gtype_d = 1'b1;
            end
            DATA: begin
                dtype_d = 2'b10;
                idx_d   = sub_d;
            end
            default: ;
        endcase
`endif
    end

    // Output register: every field describes the same character
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dtype_q <= 2'b01;
            gtype_q <= 1'b0;
            ctl0_q  <= 2'b00;
            ctl1_q  <= 2'b00;
            ctl2_q  <= 2'b00;
            idx_q   <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
        end else begin
            dtype_q <= dtype_d;
            gtype_q <= gtype_d;
            ctl0_q  <= {vsync, hsync};
            ctl1_q  <= ctl1_d;
            ctl2_q  <= ctl2_d;
            idx_q   <= idx_d;
            hpos_q  <= h_q;
            vpos_q  <= v_q;
        end
    end

    assign bus.o_dtype   = dtype_q;
    assign bus.o_gtype   = gtype_q;
    assign bus.o_ctl0    = ctl0_q;
    assign bus.o_ctl1    = ctl1_q;
    assign bus.o_ctl2    = ctl2_q;
    assign bus.o_pkt_idx = idx_q;
    assign bus.o_hpos    = hpos_q;
    assign bus.o_vpos    = vpos_q;
endmodule

// File: tb/tb_hdmi_period_sched.sv
// Directed bench for hdmi_period_sched with a reduced 80x4 raster.
// Expectations switch with HDMI_ISLAND_EN so the same file covers both builds.
module tb_hdmi_period_sched;
`ifdef HDMI_ISLAND_EN
    localparam bit ISL = 1'b1;
`else
    localparam bit ISL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdmi_period_sched_if bus();

    hdmi_period_sched #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNCW(4), .H_TOTAL(80),
        .V_ACTIVE(2),  .V_FRONT(1), .V_SYNCW(1), .V_TOTAL(4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // expected packing: {dtype, gtype, ctl0, ctl1, ctl2, ready, idx}
    typedef struct {
        int          h;
        int          v;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [14:0] cur();
        return {bus.o_dtype, bus.o_gtype, bus.o_ctl0, bus.o_ctl1, bus.o_ctl2,
                bus.o_pkt_ready, bus.o_pkt_idx};
    endfunction

    function automatic logic [14:0] pk(input logic [1:0] dt, input logic g, input logic [1:0] c0,
                                       input logic [1:0] c1, input logic [1:0] c2,
                                       input logic r, input logic [4:0] idx);
        return {dt, g, c0, c1, c2, r, idx};
    endfunction

    task automatic add(input int h, input int v, input logic [14:0] e);
        vec_t x;
        x.h = h; x.v = v; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge clk);
            if (int'(bus.o_hpos) == h && int'(bus.o_vpos) == v) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL timeout waiting for h=%0d v=%0d", h, v);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        bit ok;
        for (int i = lo; i < hi; i++) begin
            wait_pos(vecs[i].h, vecs[i].v, ok);
            if (ok) chk($sformatf("vec%0d h=%0d v=%0d", i, vecs[i].h, vecs[i].v),
                        64'(cur()), 64'(vecs[i].exp));
        end
    endtask

    // Whole-run monitors: ctl0 follows sync, ready only at h=19, no island output when disabled
    bit mon_en = 1'b0;
    int ctl0_bad = 0, rdy_bad = 0, isl_bad = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_ctl0 !== {bus.o_vpos == 12'd3, bus.o_hpos >= 12'd20 && bus.o_hpos < 12'd24})
                ctl0_bad++;
            if (bus.o_pkt_ready !== (ISL && rst_n && bus.o_hpos == 12'd19))
                rdy_bad++;
            if (!ISL && (bus.o_dtype == 2'b10 || bus.o_gtype == 1'b1))
                isl_bad++;
        end
    end

    initial begin
        bit ok;
        int p1, p2, n10;
        logic [38:0] rst_exp;
        rst_exp = {12'd0, 12'd0, pk(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0)};
        bus.i_pkt_valid = 1'b0;

        // Free-run frame, i_pkt_valid low
        add( 0, 0, pk(2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(15, 0, pk(2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(16, 0, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(19, 0, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, ISL, 0));
        add(20, 0, pk(2'b01, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        add(23, 0, pk(2'b01, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        add(24, 0, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(30, 0, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(69, 0, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(70, 0, pk(2'b01, 0, 2'b00, 2'b01, 2'b00, 0, 0));
        add(77, 0, pk(2'b01, 0, 2'b00, 2'b01, 2'b00, 0, 0));
        add(78, 0, pk(2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(79, 0, pk(2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add( 0, 1, pk(2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(15, 1, pk(2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(70, 1, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(78, 1, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add( 0, 2, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(70, 2, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(79, 2, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add( 0, 3, pk(2'b01, 0, 2'b10, 2'b00, 2'b00, 0, 0));
        add(21, 3, pk(2'b01, 0, 2'b11, 2'b00, 2'b00, 0, 0));
        add(70, 3, pk(2'b01, 0, 2'b10, 2'b01, 2'b00, 0, 0));
        add(78, 3, pk(2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 0));
        add(79, 3, pk(2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 0));
        add( 0, 0, pk(2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        p1 = vecs.size();

        // i_pkt_valid held high: island on every line when enabled
        add(19, 1, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, ISL, 0));
        add(20, 1, ISL ? pk(2'b01, 0, 2'b01, 2'b01, 2'b01, 0, 0) : pk(2'b01, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        add(27, 1, ISL ? pk(2'b01, 0, 2'b00, 2'b01, 2'b01, 0, 0) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(28, 1, ISL ? pk(2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(29, 1, ISL ? pk(2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(30, 1, ISL ? pk(2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(45, 1, ISL ? pk(2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 15) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(61, 1, ISL ? pk(2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 31) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(62, 1, ISL ? pk(2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(63, 1, ISL ? pk(2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(64, 1, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        add(19, 2, pk(2'b01, 0, 2'b00, 2'b00, 2'b00, ISL, 0));
        add(19, 3, pk(2'b01, 0, 2'b10, 2'b00, 2'b00, ISL, 0));
        add(30, 3, ISL ? pk(2'b10, 0, 2'b10, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b10, 2'b00, 2'b00, 0, 0));
        add(62, 3, ISL ? pk(2'b00, 1, 2'b10, 2'b00, 2'b00, 0, 0) : pk(2'b01, 0, 2'b10, 2'b00, 2'b00, 0, 0));
        p2 = vecs.size();

        // Reset values, checked while reset is held
        @(negedge clk);
        chk("reset_hold", 64'({bus.o_hpos, bus.o_vpos, cur()}), 64'(rst_exp));
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        run_range(0, p1);

        bus.i_pkt_valid = 1'b1;
        run_range(p1, p2);
        bus.i_pkt_valid = 1'b0;

        // Valid pulsed beside, but not on, the ready cycle
        wait_pos(18, 0, ok);
        bus.i_pkt_valid = 1'b1;
        @(negedge clk);
        chk("pulse_h19_ready", 64'(bus.o_pkt_ready), 64'(ISL));
        bus.i_pkt_valid = 1'b0;
        @(negedge clk);
        bus.i_pkt_valid = 1'b1;
        chk("pulse_h20", 64'(cur()), 64'(pk(2'b01, 0, 2'b01, 2'b00, 2'b00, 0, 0)));
        @(negedge clk);
        bus.i_pkt_valid = 1'b0;
        wait_pos(30, 0, ok);
        if (ok) chk("pulse_h30_no_island", 64'(cur()), 64'(pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0)));

        // Reset in the middle of an island
        bus.i_pkt_valid = 1'b1;
        wait_pos(40, 1, ok);
        if (ok) chk("mid_island_h40", 64'(cur()),
                    64'(ISL ? pk(2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 10) : pk(2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
        rst_n = 1'b0;
        bus.i_pkt_valid = 1'b0;
        #1;
        chk("reset_immediate", 64'({bus.o_hpos, bus.o_vpos, cur()}), 64'(rst_exp));
        @(negedge clk);
        chk("reset_cycle1", 64'({bus.o_hpos, bus.o_vpos, cur()}), 64'(rst_exp));
        @(negedge clk);
        chk("reset_cycle2", 64'({bus.o_hpos, bus.o_vpos, cur()}), 64'(rst_exp));
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_0_0", 64'({bus.o_hpos, bus.o_vpos, bus.o_dtype, bus.o_pkt_idx}),
            64'({12'd0, 12'd0, 2'b11, 5'd0}));
        n10 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_dtype == 2'b10 || bus.o_pkt_idx != 5'd0) n10++;
        end
        chk("no_residual_island", 64'(n10), 64'd0);
        wait_pos(78, 0, ok);
        if (ok) chk("post_reset_guard", 64'(cur()), 64'(pk(2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0)));

        mon_en = 1'b0;
        chk("ctl0_monitor", 64'(ctl0_bad), 64'd0);
        chk("ready_monitor", 64'(rdy_bad), 64'd0);
        chk("island_disabled_monitor", 64'(isl_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
